inport_uart_rx: RTL and testbench



---
 rtl/inport_uart_pkg.sv | 16 +
 rtl/uart_byte_rx.sv | 142 ++++++++++++++
 rtl/inport_uart_rx.sv | 99 +++++++++
 tb/tb_inport_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inport_uart_pkg.sv
// Shared types and constants for the serial input-port receiver.
//   rx_state_t  : byte-level receive FSM states
//   BYTE_SLOT_W : width of the byte-slot counter (four bytes per word)
package inport_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    localparam int BYTE_SLOT_W = 2;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchronizer, byte FSM and mid-bit sampling counter.
//   clk, reset  : system clock, asynchronous active-low reset
//   rx          : raw serial line (idles high, asynchronous to clk)
//   byte_data   : received byte, valid while byte_done is high
//   byte_done   : high in the stop-sample cycle of a correctly framed byte
//   frame_err   : registered one-cycle pulse after a stop bit samples low
//   busy        : high whenever the FSM is not idle
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | line idle, waiting for a falling edge
// S_START     | counting half a bit to the start-bit centre
// S_DATA      | sampling 8 data bits at bit centres, LSB first
// S_STOP      | waiting for the stop-bit centre
// S_WAIT_HIGH | after a framing error, wait for the line to return high
module uart_byte_rx
    import inport_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic            rx_meta;
    logic            rx_s;
    logic            rx_prev;
    rx_state_t       state;
    rx_state_t       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_nxt;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_nxt;
    logic            frame_err_nxt;
    logic            expired;

    // Synchronizer and edge-detect history all reset to the idle (high) level
    // so that releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    assign expired = (bit_cnt == '0);

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = expired ? bit_cnt : bit_cnt - 1'b1;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_reg;
        frame_err_nxt = 1'b0;
        byte_done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt   = S_START;
                    bit_cnt_nxt = HALF_LOAD;
                end
            end
            S_START: begin
                if (expired) begin
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = FULL_LOAD;
                        bit_idx_nxt = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_nxt   = {rx_s, shift_reg[7:1]};
                    bit_cnt_nxt = FULL_LOAD;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (expired) begin
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The shift register is complete during the stop-sample cycle, which is
    // exactly when byte_done is asserted.
    assign byte_data = shift_reg;
    assign busy      = (state != S_IDLE);

endmodule

// File: rtl/inport_uart_rx.sv
// Serial-to-parallel input-port producer: assembles four 8N1 bytes, LSB byte
// first, into a 32-bit word presented atomically to the processor input port.
//   clk, reset      : system clock, asynchronous active-low reset
//   in_rx           : raw serial line
//   out_inport_data : last complete word, stable between updates
//   out_word_valid  : one-cycle pulse when out_inport_data updates
//   out_frame_err   : one-cycle pulse on a low stop bit
//   out_timeout     : one-cycle pulse when a partial word is discarded
//   out_busy        : byte receiver is not idle
module inport_uart_rx
    import inport_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_rx,
    output logic [31:0] out_inport_data,
    output logic        out_word_valid,
    output logic        out_frame_err,
    output logic        out_timeout,
    output logic        out_busy
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;

    logic [7:0]             byte_data;
    logic                   byte_done;
    logic                   byte_busy;
    logic                   frame_err;
    logic [BYTE_SLOT_W-1:0] byte_cnt;
    logic [23:0]            staging;
    logic [TO_W-1:0]        to_cnt;
    logic                   to_hit;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (in_rx),
        .byte_data (byte_data),
        .byte_done (byte_done),
        .frame_err (frame_err),
        .busy      (byte_busy)
    );

    // to_cnt counts idle cycles with a partial word pending; the hit fires on
    // the TO_LIMIT-th such cycle.
    assign to_hit = !byte_busy && (byte_cnt != '0) && (to_cnt == TO_W'(TO_LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (byte_busy || (byte_cnt == '0) || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Byte slot 3 bypasses staging: the last byte goes straight into the
    // output word so that only complete words are ever presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt        <= '0;
            staging         <= '0;
            out_inport_data <= '0;
            out_word_valid  <= 1'b0;
            out_timeout     <= 1'b0;
        end else begin
            out_word_valid <= 1'b0;
            out_timeout    <= 1'b0;
            if (frame_err) begin
                byte_cnt <= '0;
            end else if (byte_done) begin
                byte_cnt <= byte_cnt + 1'b1;
                unique case (byte_cnt)
                    2'd0:    staging[7:0]   <= byte_data;
                    2'd1:    staging[15:8]  <= byte_data;
                    2'd2:    staging[23:16] <= byte_data;
                    default: begin
                        out_inport_data <= {byte_data, staging};
                        out_word_valid  <= 1'b1;
                    end
                endcase
            end else if (to_hit) begin
                byte_cnt    <= '0;
                out_timeout <= 1'b1;
            end
        end
    end

    assign out_frame_err = frame_err;
    assign out_busy      = byte_busy;

endmodule

// File: tb/tb_inport_uart_rx.sv
module tb_inport_uart_rx;

    localparam int C        = 8;
    localparam int TOB      = 4;
    localparam int H        = C / 2;
    localparam int TO_LIMIT = TOB * C;
    // raw start edge -> 2 sync cycles -> half bit + 9 bits to stop sample -> +1 register
    localparam int LAT      = 3 + H + 9 * C;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_rx;
    logic [31:0] out_inport_data;
    logic        out_word_valid;
    logic        out_frame_err;
    logic        out_timeout;
    logic        out_busy;

    inport_uart_rx #(
        .CLKS_PER_BIT(C),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_rx           (in_rx),
        .out_inport_data (out_inport_data),
        .out_word_valid  (out_word_valid),
        .out_frame_err   (out_frame_err),
        .out_timeout     (out_timeout),
        .out_busy        (out_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0, n_ferr = 0, n_to = 0;
    int valid_cyc = -1, ferr_cyc = -1, to_cyc = -1;
    always @(negedge clk) begin
        if (out_word_valid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (out_frame_err) begin
            n_ferr   <= n_ferr + 1;
            ferr_cyc <= cyc;
        end
        if (out_timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: bytes of the word in progress, plus expected event counts.
    logic [7:0]  mq[$];
    logic [31:0] exp_word = 32'h0;
    int          exp_valid = 0, exp_ferr = 0, exp_to = 0;
    int          last_s = 0;
    bit          to_pending = 1'b0;
    int          exp_to_cyc = 0;

    task automatic drive_bit(input logic v);
        in_rx = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        if (to_pending) begin
            chk_eq({tag, "_to_time"}, to_cyc, exp_to_cyc);
            to_pending = 1'b0;
        end
        chk_eq({tag, "_word"}, out_inport_data, exp_word);
        chk_eq({tag, "_n_valid"}, n_valid, exp_valid);
        chk_eq({tag, "_n_ferr"}, n_ferr, exp_ferr);
        chk_eq({tag, "_n_to"}, n_to, exp_to);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int hold_low);
        int s;
        s = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) begin
            repeat (hold_low) @(posedge clk);
            #1;
            in_rx = 1'b1;
            repeat (C) @(posedge clk);
            #1;
        end
        if (stop_ok) begin
            mq.push_back(b);
            last_s = s;
            if (mq.size() == 4) begin
                exp_word = {mq[3], mq[2], mq[1], mq[0]};
                exp_valid++;
                mq.delete();
                chk_eq("word_time", valid_cyc, s + LAT);
            end
        end else begin
            mq.delete();
            exp_ferr++;
            chk_eq("ferr_time", ferr_cyc, s + LAT);
        end
        check_state("byte");
    endtask

    // Idle the line for g cycles after a good byte. The FSM is already idle for
    // the C-H cycles after the stop-bit centre, and the start-detect cycle
    // itself is an idle cycle, so the partial word expires when g+C-H reaches
    // the timeout length.
    task automatic gap(input int g);
        if (mq.size() != 0 && (g + (C - H)) >= TO_LIMIT) begin
            mq.delete();
            exp_to++;
            exp_to_cyc = last_s + LAT + TO_LIMIT;
            to_pending = 1'b1;
        end
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        logic [7:0] rb;
        reset = 1'b0;
        in_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk_eq("rst_data", out_inport_data, 32'h0);
        chk_eq("rst_valid", 32'(out_word_valid), 32'h0);
        chk_eq("rst_ferr", 32'(out_frame_err), 32'h0);
        chk_eq("rst_to", 32'(out_timeout), 32'h0);
        chk_eq("rst_busy", 32'(out_busy), 32'h0);

        // Full word back-to-back
        gap(C);
        send_word(32'hDEADBEEF);

        // Glitch: 3-cycle low pulse
        gap(C);
        s = cyc;
        in_rx = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        in_rx = 1'b1;
        @(posedge clk); #1;
        chk_eq("glitch_busy_hi", 32'(out_busy), 32'h1);
        repeat (5) begin @(posedge clk); #1; end
        chk_eq("glitch_busy_lo", 32'(out_busy), 32'h0);
        check_state("glitch");

        // Framing error, line held low, then a good word
        gap(C);
        send_byte(8'h55, 1'b0, 20);
        send_word(32'h44332211);

        // Timeout: two bytes, long idle, then a fresh word
        gap(C);
        send_byte(8'hA1, 1'b1, 0);
        send_byte(8'hA2, 1'b1, 0);
        gap(40);
        send_word(32'h04030201);

        // Timeout boundary: one short of expiry keeps the partial word
        send_byte(8'h5A, 1'b1, 0);
        send_byte(8'hC3, 1'b1, 0);
        gap(TO_LIMIT - (C - H) - 1);
        send_byte(8'h3C, 1'b1, 0);
        send_byte(8'h96, 1'b1, 0);
        // Exact expiry coincides with the next start edge
        send_byte(8'h77, 1'b1, 0);
        gap(TO_LIMIT - (C - H));
        send_word(32'hCAFEF00D);

        // Reset mid-operation: after two bytes and mid data bit of the third
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b1, 0);
        drive_bit(1'b0);
        in_rx = 1'b1;
        repeat (H) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("midrst_data", out_inport_data, 32'h0);
        chk_eq("midrst_busy", 32'(out_busy), 32'h0);
        mq.delete();
        exp_word = 32'h0;
        to_pending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        gap(C);
        send_word(32'h8899AABB);

        // Consecutive words
        send_word(32'h13579BDF);
        send_word(32'h2468ACE0);

        // Randomized traffic: random bytes, gaps and occasional framing errors
        for (int n = 0; n < 24; n++) begin
            gap($urandom_range(0, 40));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)
                send_byte(rb, 1'b0, $urandom_range(0, 20));
            else
                send_byte(rb, 1'b1, 0);
        end

        gap(50);
        repeat (10) @(posedge clk);
        #1;
        check_state("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
